buzzer_event_decoder: RTL and testbench

Receive-side monitor for the three one-hot buzzer alert lines driven by the sensor alarm block. It synchronises the lines, measures each alert pulse, and classifies it as valid, short, long, or multi-hot/glitched. Each classified event goes into a small FIFO read through a valid/ready handshake. Saturating counters summarise activity. It sits between the alarm outputs and the host/status logic, or in the bench as the checker for the alarm block.

---
 rtl/buzzer_event_decoder_pkg.sv | 68 ++++++
 rtl/buzzer_event_decoder_if.sv | 12 +
 rtl/buzzer_event_decoder_evt_fifo.sv | 84 ++++++++
 rtl/buzzer_event_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_buzzer_event_decoder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_event_decoder_pkg.sv
// Shared definitions for the buzzer event decoder slice.
// Holds status/channel/state encodings, the event word layout and
// small helpers used to build and interpret event words.
package buzzer_pkg;

  // Event word layout: {status, chan, len}
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned CHAN_W   = 2;
  localparam int unsigned ST_W     = 2;
  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned CHAN_LSB = LEN_LSB + LEN_W;
  localparam int unsigned ST_LSB   = CHAN_LSB + CHAN_W;
  localparam int unsigned EVT_W    = ST_LSB + ST_W;

  typedef enum logic [ST_W-1:0] {
    ST_OK    = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2,
    ST_MULTI = 2'd3
  } status_e;

  typedef enum logic [CHAN_W-1:0] {
    CH_NONE = 2'd0,
    CH_1    = 2'd1,
    CH_2    = 2'd2,
    CH_3    = 2'd3
  } chan_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_GAP     = 2'd2
  } state_e;

  function automatic logic [EVT_W-1:0] pack_evt(status_e st, chan_e ch,
                                                logic [LEN_W-1:0] len);
    logic [EVT_W-1:0] evt;
    evt                      = '0;
    evt[ST_LSB   +: ST_W]    = st;
    evt[CHAN_LSB +: CHAN_W]  = ch;
    evt[LEN_LSB  +: LEN_W]   = len;
    return evt;
  endfunction

  // Single active line -> channel number; anything else -> CH_NONE.
  function automatic chan_e onehot_to_chan(logic [2:0] lines);
    chan_e ch;
    case (lines)
      3'b001:  ch = CH_1;
      3'b010:  ch = CH_2;
      3'b100:  ch = CH_3;
      default: ch = CH_NONE;
    endcase
    return ch;
  endfunction

  function automatic logic [2:0] chan_to_onehot(chan_e ch);
    logic [2:0] lines;
    case (ch)
      CH_1:    lines = 3'b001;
      CH_2:    lines = 3'b010;
      CH_3:    lines = 3'b100;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/buzzer_event_decoder_if.sv
// Event stream interface of the buzzer event decoder.
//   evt_valid : head event present (source -> sink)
//   evt_data  : head event word {status, chan, len} (source -> sink)
//   evt_ready : sink accepts head event (sink -> source)
interface buzzer_event_decoder_if;
  logic                        evt_valid;
  logic                        evt_ready;
  logic [buzzer_pkg::EVT_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface

// File: rtl/buzzer_event_decoder_evt_fifo.sv
// Small event FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data (ignored when full unless a pop frees space)
//   wr_data    : word to write
//   pop        : remove head (ignored when empty)
//   rd_data    : registered head word, zero when empty
//   full/empty : occupancy flags
module evt_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_data = head_q;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_nxt;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

    // Head tracks the next-cycle front entry; a push into a FIFO that is
    // (or becomes) empty bypasses storage straight to the head.
    head_d = head_q;
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (cnt_q == CW'(1)) ? wr_data : mem_q[rd_nxt];
    end else if (empty) begin
      head_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/buzzer_event_decoder.sv
// Receive-side monitor for the three one-hot buzzer alert lines.
// Synchronises the lines, measures each pulse, classifies it and queues
// the resulting event word; saturating counters summarise activity.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : decoder enable (FIFO and counters stay accessible when low)
//   buz_in     : asynchronous buzzer lines, bit0=ch1 .. bit2=ch3
//   clr        : synchronous clear of ok_cnt, err_cnt, ovf
//   evt        : event stream (valid/ready, {status, chan, len})
//   ok_cnt     : OK events, saturating
//   err_cnt    : non-OK events, saturating
//   ovf        : sticky, an event was dropped on a full FIFO
module buzzer_event_decoder
  import buzzer_pkg::*;
#(
  parameter int unsigned MIN_LEN = 28,
  parameter int unsigned MAX_LEN = 34,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [2:0]             buz_in,
  input  logic                   clr,
  buzzer_event_decoder_if.master evt,
  output logic [7:0]             ok_cnt,
  output logic [7:0]             err_cnt,
  output logic                   ovf
);

  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  logic [2:0]       s1_q, s1_d;
  logic [2:0]       bs_q, bs_d;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  chan_e            chan_q, chan_d;
  logic [7:0]       ok_q, ok_d;
  logic [7:0]       err_q, err_d;
  logic             ovf_q, ovf_d;

  chan_e            bs_chan;
  logic             bs_same;
  logic             push;
  status_e          push_st;
  chan_e            push_ch;
  logic [LEN_W-1:0] push_len;
  logic [EVT_W-1:0] push_data;
  logic             pop_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EVT_W-1:0] fifo_head;

  // Two-flop synchroniser; runs regardless of ena.
  always_comb begin
    s1_d = buz_in;
    bs_d = s1_q;
  end

  assign bs_chan = onehot_to_chan(bs_q);
  assign bs_same = (bs_q == chan_to_onehot(chan_q));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bs_chan != CH_NONE) begin
            state_d = S_MEASURE;
          end else if (bs_q != '0) begin
            state_d = S_GAP;
          end
        end
        S_MEASURE: begin
          if (bs_q == '0) begin
            state_d = S_IDLE;
          end else if (!bs_same) begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (bs_q == '0) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: event push and pulse measurement datapath
  always_comb begin
    push     = 1'b0;
    push_st  = ST_OK;
    push_ch  = CH_NONE;
    push_len = '0;
    len_d    = len_q;
    chan_d   = chan_q;
    if (!ena) begin
      len_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bs_chan != CH_NONE) begin
            chan_d = bs_chan;
            len_d  = LEN_W'(1);
          end else if (bs_q != '0) begin
            push    = 1'b1;
            push_st = ST_MULTI;
          end
        end
        S_MEASURE: begin
          if (bs_same) begin
            len_d = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
          end else begin
            push     = 1'b1;
            push_ch  = chan_q;
            push_len = len_q;
            if (bs_q != '0) begin
              push_st = ST_MULTI;
            end else if (len_q < LEN_W'(MIN_LEN)) begin
              push_st = ST_SHORT;
            end else if (len_q > LEN_W'(MAX_LEN)) begin
              push_st = ST_LONG;
            end else begin
              push_st = ST_OK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign push_data = pack_evt(push_st, push_ch, push_len);
  assign pop_fire  = evt.evt_valid && evt.evt_ready;

  // Counters count push attempts, so dropped events are still counted.
  always_comb begin
    ok_d  = ok_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      ok_d  = '0;
      err_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push && (push_st == ST_OK) && (ok_q != '1)) begin
        ok_d = ok_q + 8'd1;
      end
      if (push && (push_st != ST_OK) && (err_q != '1)) begin
        err_d = err_q + 8'd1;
      end
      if (push && fifo_full && !pop_fire) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      bs_q   <= '0;
      len_q  <= '0;
      chan_q <= CH_NONE;
      ok_q   <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      bs_q   <= bs_d;
      len_q  <= len_d;
      chan_q <= chan_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
    end
  end

  evt_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop_fire),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_data  = fifo_head;
  assign ok_cnt        = ok_q;
  assign err_cnt       = err_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_buzzer_event_decoder.sv
// Directed self-checking bench for buzzer_event_decoder (default parameters).
module tb_buzzer_event_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] buz_in;
  logic       clr;
  logic [7:0] ok_cnt;
  logic [7:0] err_cnt;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_event_decoder_if evt_if ();

  buzzer_event_decoder #(
    .MIN_LEN (28),
    .MAX_LEN (34),
    .DEPTH   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .buz_in  (buz_in),
    .clr     (clr),
    .evt     (evt_if),
    .ok_cnt  (ok_cnt),
    .err_cnt (err_cnt),
    .ovf     (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event word {status, chan, len} built independently of the RTL.
  function automatic logic [31:0] mk(input int st, input int ch, input int len);
    logic [9:0] w;
    w = {st[1:0], ch[1:0], len[5:0]};
    return 32'(w);
  endfunction

  task automatic hold(input logic [2:0] v, input int n);
    buz_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for evt_valid at a falling edge and returns the head word.
  task automatic wait_evt(input string tag, output logic [31:0] d);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (evt_if.evt_valid) break;
    end
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 1);
    d = 32'(evt_if.evt_data);
  endtask

  logic [31:0] d;

  initial begin
    rst_n            = 1'b0;
    ena              = 1'b0;
    buz_in           = 3'b000;
    clr              = 1'b0;
    evt_if.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(evt_if.evt_valid), 0);
    check("rst_data",  32'(evt_if.evt_data),  0);
    check("rst_ok",    32'(ok_cnt),           0);
    check("rst_err",   32'(err_cnt),          0);
    check("rst_ovf",   32'(ovf),              0);
    rst_n            = 1'b1;
    ena              = 1'b1;
    evt_if.evt_ready = 1'b1;
    repeat (3) @(negedge clk);

    // OK pulse on ch2 with explicit fall-to-valid latency
    hold(3'b010, 31);
    buz_in = 3'b000;
    @(negedge clk); check("lat_e0", 32'(evt_if.evt_valid), 0);
    @(negedge clk); check("lat_e1", 32'(evt_if.evt_valid), 0);
    @(negedge clk); check("lat_e2", 32'(evt_if.evt_valid), 1);
    check("ok31_data", 32'(evt_if.evt_data), mk(0, 2, 31));
    check("ok31_ok",   32'(ok_cnt),  1);
    check("ok31_err",  32'(err_cnt), 0);
    @(negedge clk); check("ok31_popped", 32'(evt_if.evt_valid), 0);

    // SHORT and LONG
    hold(3'b001, 10); buz_in = 3'b000;
    wait_evt("short10", d);
    check("short10_data", d, mk(1, 1, 10));
    check("short10_err", 32'(err_cnt), 1);
    hold(3'b100, 40); buz_in = 3'b000;
    wait_evt("long40", d);
    check("long40_data", d, mk(2, 3, 40));
    check("long40_err", 32'(err_cnt), 2);

    // Multi-hot from idle, then nothing until the lines drop
    buz_in = 3'b011;
    wait_evt("multi", d);
    check("multi_data", d, mk(3, 0, 0));
    repeat (6) @(negedge clk);
    check("multi_gap_held", 32'(evt_if.evt_valid), 0);
    hold(3'b000, 6);
    check("multi_gap_release", 32'(evt_if.evt_valid), 0);
    check("multi_err", 32'(err_cnt), 3);

    // Channel switch mid-pulse
    hold(3'b001, 8);
    buz_in = 3'b100;
    wait_evt("switch", d);
    check("switch_data", d, mk(3, 1, 8));
    hold(3'b100, 5);
    hold(3'b000, 6);
    check("switch_no_more", 32'(evt_if.evt_valid), 0);
    check("switch_err", 32'(err_cnt), 4);

    // Clear
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_ok",  32'(ok_cnt),  0);
    check("clr_err", 32'(err_cnt), 0);
    check("clr_ovf", 32'(ovf),     0);

    // Six back-to-back OK pulses (one low cycle apart) into a stalled FIFO
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hold(3'b001, 28 + i);
      hold(3'b000, 1);
    end
    repeat (6) @(negedge clk);
    check("full_valid", 32'(evt_if.evt_valid), 1);
    check("full_ovf",   32'(ovf),     1);
    check("full_ok",    32'(ok_cnt),  6);
    check("full_err",   32'(err_cnt), 0);
    @(negedge clk);
    check("full_stable", 32'(evt_if.evt_data), mk(0, 1, 28));
    evt_if.evt_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("drain_data", 32'(evt_if.evt_data), mk(0, 1, 28 + i));
    end
    @(negedge clk);
    check("drain_empty", 32'(evt_if.evt_valid), 0);
    check("drain_zero",  32'(evt_if.evt_data),  0);

    // Asynchronous reset mid-pulse with a queued event
    evt_if.evt_ready = 1'b0;
    hold(3'b001, 30); buz_in = 3'b000;
    wait_evt("pre_rst", d);
    check("pre_rst_ok", 32'(ok_cnt), 7);
    hold(3'b010, 10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(evt_if.evt_valid), 0);
    check("arst_data",  32'(evt_if.evt_data),  0);
    check("arst_ok",    32'(ok_cnt),           0);
    check("arst_err",   32'(err_cnt),          0);
    check("arst_ovf",   32'(ovf),              0);
    @(negedge clk);
    rst_n            = 1'b1;
    evt_if.evt_ready = 1'b1;
    hold(3'b010, 20); buz_in = 3'b000;
    wait_evt("post_rst", d);
    check("post_rst_data", d, mk(1, 2, 20));
    check("post_rst_err", 32'(err_cnt), 1);

    // Enable dropped mid-pulse: discarded
    hold(3'b100, 15);
    ena = 1'b0;
    hold(3'b100, 5);
    hold(3'b000, 8);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    check("ena_drop_valid", 32'(evt_if.evt_valid), 0);
    check("ena_drop_err",   32'(err_cnt), 1);
    check("ena_drop_ok",    32'(ok_cnt),  0);

    // Enable raised during an active line: measured from first enabled edge
    ena = 1'b0;
    hold(3'b001, 5);
    ena = 1'b1;
    hold(3'b001, 26); buz_in = 3'b000;
    wait_evt("ena_rise", d);
    check("ena_rise_data", d, mk(0, 1, 28));
    check("ena_rise_ok", 32'(ok_cnt), 1);

    // Length saturation and classification boundaries
    hold(3'b001, 70); buz_in = 3'b000;
    wait_evt("sat", d);
    check("sat_data", d, mk(2, 1, 63));
    hold(3'b010, 27); buz_in = 3'b000;
    wait_evt("b27", d);
    check("b27_data", d, mk(1, 2, 27));
    hold(3'b010, 35); buz_in = 3'b000;
    wait_evt("b35", d);
    check("b35_data", d, mk(2, 2, 35));
    hold(3'b010, 34); buz_in = 3'b000;
    wait_evt("b34", d);
    check("b34_data", d, mk(0, 2, 34));
    check("bnd_err", 32'(err_cnt), 4);
    check("bnd_ok",  32'(ok_cnt),  2);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      hold(3'b010, 30);
      hold(3'b000, 2);
    end
    repeat (6) @(negedge clk);
    check("sat_ok",  32'(ok_cnt),  255);
    check("sat_err", 32'(err_cnt), 4);

    // clr coincident with an OK push at ok_cnt=255
    hold(3'b010, 30);
    buz_in = 3'b000;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrpush_ok",    32'(ok_cnt),  0);
    check("clrpush_err",   32'(err_cnt), 0);
    check("clrpush_valid", 32'(evt_if.evt_valid), 1);
    check("clrpush_data",  32'(evt_if.evt_data), mk(0, 2, 30));
    @(negedge clk);
    check("clrpush_pop", 32'(evt_if.evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
